// File: rtl/full_adder_checker.sv
// Hardware exerciser for a 1-bit full adder: walks all eight operand vectors,
// samples the adder response after a settle window and reports pass/fail results.
module full_adder_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c_in,
  input  logic       sum,
  input  logic       carry_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] ops_n;
  logic [3:0] err_n;
  logic [2:0] ff_n;
  logic       exp_sum, exp_carry, mismatch;

  assign exp_sum   = a ^ b ^ c_in;
  assign exp_carry = (a & b) | (a & c_in) | (b & c_in);
  assign mismatch  = (sum != exp_sum) || (carry_out != exp_carry);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    ops_n   = {a, b, c_in};
    err_n   = err_count;
    ff_n    = first_fail;
    case (state)
      IDLE, DONE: begin
        ops_n = '0;
        if (start) begin
          state_n = DRIVE;
          idx_n   = '0;
          cnt_n   = '0;
          err_n   = '0;
          ff_n    = '0;
        end
      end
      DRIVE: begin
        ops_n = idx;
        cnt_n = cnt + 8'd1;
        if (cnt == 8'(SETTLE_CYCLES - 1))
          state_n = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          err_n = err_count + 4'd1;
          if (err_count == 4'd0)
            ff_n = idx;
        end
        if (idx == 3'd7) begin
          state_n = DONE;
          ops_n   = '0;
        end else begin
          state_n = DRIVE;
          idx_n   = idx + 3'd1;
          cnt_n   = '0;
          ops_n   = idx + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status flags are registered from next-state values so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      {a, b, c_in} <= '0;
      err_count  <= '0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      {a, b, c_in} <= ops_n;
      err_count  <= err_n;
      first_fail <= ff_n;
      busy       <= (state_n == DRIVE) || (state_n == CHECK);
      done       <= (state_n == DONE);
      pass       <= (state_n == DONE) && (err_n == 4'd0);
    end
  end

endmodule
